// File: rtl/fp16_mac_seq_drain_if.sv
// Operand-in and result-out valid/ready streams of the FP16 MAC sequencer.
// The master drives operands and result backpressure; the slave is the sequencer.
interface fp16_mac_seq_drain_if;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_w;
    logic        op_last;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;

    modport master (
        output op_valid, op_a, op_w, op_last, res_ready,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_a, op_w, op_last, res_ready,
        output op_ready, res_valid, res_data
    );
endinterface

// File: rtl/fp16_mac_seq_drain.sv
// Sequencer and result drain for one FP16 MAC PE: feeds operand vectors, flushes, queues sums.
// Optional macro RELU_EN clamps negative (sign-bit set) results to +0 before queuing.
module fp16_mac_seq_drain #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fp16_mac_seq_drain_if.slave           bus,
    output logic [15:0]                   mac_a,
    output logic [15:0]                   mac_w,
    output logic                          mac_enable,
    output logic                          mac_acc_clear,
    input  logic [15:0]                   mac_acc_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              vec_count,
    output logic                          busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {RUN, FLUSH, CAPTURE} state_t;

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [15:0]      mem_q [0:FIFO_DEPTH-1];

    logic             accept;
    logic             push;
    logic             pop;
    logic [15:0]      push_data;

    always_comb begin
        push_data = mac_acc_out;
`ifdef RELU_EN
        if (mac_acc_out[15]) push_data = 16'h0000;
`else
        push_data = mac_acc_out;
`endif
    end

    // Admission is decided on the first pair only, so a started vector always has a slot.
    always_comb begin
        bus.op_ready  = 1'b0;
        mac_a         = 16'h0000;
        mac_w         = 16'h0000;
        mac_enable    = 1'b0;
        mac_acc_clear = 1'b0;
        accept        = 1'b0;
        case (state_q)
            RUN: begin
                bus.op_ready  = first_q ? (count_q < CW'(FIFO_DEPTH)) : 1'b1;
                accept        = bus.op_valid & bus.op_ready;
                mac_a         = bus.op_a;
                mac_w         = bus.op_w;
                mac_enable    = accept;
                mac_acc_clear = accept & first_q;
            end
            FLUSH: begin
                mac_enable    = 1'b1;
                mac_acc_clear = 1'b1;
            end
            default: ;
        endcase
    end

    assign push          = (state_q == CAPTURE);
    assign bus.res_valid = (count_q != '0);
    assign pop           = bus.res_valid & bus.res_ready;
    assign bus.res_data  = bus.res_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign fifo_count    = count_q;
    assign vec_count     = vec_q;
    assign busy          = !first_q || (state_q != RUN);

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vec_d    = vec_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    first_d = bus.op_last;
                    if (bus.op_last) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = CAPTURE;
            CAPTURE: state_d = RUN;
            default: state_d = RUN;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            vec_d    = vec_q + CNT_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            first_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vec_q    <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vec_q    <= vec_d;
        end
    end

    // Storage needs no reset: entries are only observable once the count covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: tb/tb_fp16_mac_seq_drain.sv
// Bench for fp16_mac_seq_drain: exact-arithmetic PE stand-in, real-valued reference model
// checked every cycle, plus directed vectors with literal expected results.
module tb_fp16_mac_seq_drain;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mac_a, mac_w, mac_acc_out;
    logic        mac_enable, mac_acc_clear;
    logic [2:0]  fifo_count;
    logic [CNT_W-1:0] vec_count;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    fp16_mac_seq_drain_if bus();

    fp16_mac_seq_drain #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mac_a(mac_a), .mac_w(mac_w), .mac_enable(mac_enable),
        .mac_acc_clear(mac_acc_clear), .mac_acc_out(mac_acc_out),
        .fifo_count(fifo_count), .vec_count(vec_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [15:0] h);
        int  e = int'(h[14:10]);
        real m = real'(h[9:0]);
        real r;
        if (e == 0) r = m / 1024.0 * pow2(-14);
        else        r = (1.0 + m / 1024.0) * pow2(e - 15);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2f(input real v);
        logic        s = (v < 0.0);
        real         a = s ? -v : v;
        int          e = 15;
        int          m;
        logic [4:0]  e5;
        logic [9:0]  m10;
        if (v == 0.0) return 16'h0000;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m   = int'((a - 1.0) * 1024.0);
        e5  = e[4:0];
        m10 = m[9:0];
        return {s, e5, m10};
    endfunction

    function automatic logic [15:0] relu(input logic [15:0] h);
`ifdef RELU_EN
        return h[15] ? 16'h0000 : h;
`else
        return h;
`endif
    endfunction

    // PE stand-in: a clear hands the old sum to acc_out and restarts from the new product.
    real pe_acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_acc      <= 0.0;
            mac_acc_out <= 16'h0000;
        end else if (mac_enable) begin
            if (mac_acc_clear) begin
                mac_acc_out <= r2f(pe_acc);
                pe_acc      <= f2r(mac_a) * f2r(mac_w);
            end else begin
                pe_acc      <= pe_acc + f2r(mac_a) * f2r(mac_w);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a vector's sum becomes a queued result two cycles after its last pair.
    real         m_sum;
    logic [15:0] m_q[$];
    logic [15:0] m_pend;
    bit          m_first;
    int          m_stall;
    int          m_vec;

    function automatic bit m_ready();
        return (m_stall == 0) && (!m_first || m_q.size() < DEPTH);
    endfunction

    initial begin
        m_sum = 0.0; m_first = 1; m_stall = 0; m_vec = 0; m_pend = 16'h0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete(); m_first = 1; m_stall = 0; m_vec = 0; m_sum = 0.0;
            end else begin
                bit          acc, pop, push;
                logic [15:0] pv;
                real         p;
                pop  = bus.res_ready && (m_q.size() > 0);
                push = (m_stall == 1);
                pv   = m_pend;
                acc  = bus.op_valid && m_ready();
                if (m_stall > 0) m_stall--;
                else if (acc) begin
                    p = f2r(bus.op_a) * f2r(bus.op_w);
                    m_sum = m_first ? p : m_sum + p;
                    if (bus.op_last) begin
                        m_pend  = relu(r2f(m_sum));
                        m_stall = 2;
                        m_first = 1;
                    end else m_first = 0;
                end
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back(pv);
                    m_vec = (m_vec + 1) % (1 << CNT_W);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic en_e, clr_e;
            en_e  = (m_stall == 2) ? 1'b1 : (m_stall == 1) ? 1'b0 : (bus.op_valid && m_ready());
            clr_e = (m_stall == 2) ? 1'b1 : (m_stall == 1) ? 1'b0 : (en_e && m_first);
            chk("res_valid", bus.res_valid, m_q.size() > 0);
            chk("res_data", bus.res_data, (m_q.size() > 0) ? m_q[0] : 16'h0000);
            chk("fifo_count", fifo_count, m_q.size());
            chk("vec_count", vec_count, m_vec);
            chk("busy", busy, !m_first || m_stall > 0);
            chk("op_ready", bus.op_ready, m_ready());
            chk("mac_enable", mac_enable, en_e);
            chk("mac_acc_clear", mac_acc_clear, clr_e);
            chk("mac_a", mac_a, (m_stall == 0) ? bus.op_a : 16'h0000);
            chk("mac_w", mac_w, (m_stall == 0) ? bus.op_w : 16'h0000);
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] w, input logic last);
        int t = 0;
        bus.op_a = a; bus.op_w = w; bus.op_last = last; bus.op_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.op_ready) break;
            t++;
            if (t > 200) begin
                n_chk++; n_fail++;
                $display("FAIL send_timeout: op_ready stayed 0 for %0d cycles", t);
                break;
            end
        end
        sync();
        bus.op_valid = 1'b0; bus.op_last = 1'b0;
    endtask

    task automatic wait3();
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_vc[5] = '{1, 2, 3, 0, 1};
        bus.op_valid = 0; bus.op_a = 0; bus.op_w = 0; bus.op_last = 0; bus.res_ready = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        chk("reset_res_valid", bus.res_valid, 0);
        chk("reset_res_data", bus.res_data, 16'h0000);
        chk("reset_op_ready", bus.op_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_mac_enable", mac_enable, 0);

        // 1*2 + 1*3 = 5.0
        sync(); bus.res_ready = 1'b1;
        send(16'h3C00, 16'h4000, 1'b0);
        send(16'h3C00, 16'h4200, 1'b1);
        @(negedge clk); chk("lat_flush_res_valid", bus.res_valid, 0);
        @(negedge clk); chk("lat_capture_res_valid", bus.res_valid, 0);
        @(negedge clk); chk("dot5_res_data", bus.res_data, 16'h4500);
        chk("dot5_vec_count", vec_count, 1);

        // single-pair vector with a negative result
        sync();
        send(16'h3C00, 16'hC200, 1'b1);
        wait3();
`ifdef RELU_EN
        chk("neg_res_data", bus.res_data, 16'h0000);
`else
        chk("neg_res_data", bus.res_data, 16'hC200);
`endif

        // fill the FIFO with backpressure, fifth vector must wait for a pop
        sync(); bus.res_ready = 1'b0;
        repeat (2) sync();
        for (int i = 0; i < 4; i++) send(16'h4000, 16'h4000, 1'b1);
        wait3();
        chk("full_fifo_count", fifo_count, 4);
        chk("full_res_data", bus.res_data, 16'h4400);
        chk("full_op_ready", bus.op_ready, 0);
        sync();
        fork
            send(16'h4000, 16'h4000, 1'b1);
            begin
                repeat (3) sync();
                bus.res_ready = 1'b1;
                sync();
                bus.res_ready = 1'b0;
            end
        join
        wait3();
        chk("refill_fifo_count", fifo_count, 4);
        sync(); bus.res_ready = 1'b1;
        repeat (6) sync();
        bus.res_ready = 1'b0;

        // pop coincides with push at count 2
        send(16'h4000, 16'h4000, 1'b1);
        send(16'h3C00, 16'h4000, 1'b1);
        wait3();
        chk("pre_pushpop_count", fifo_count, 2);
        sync();
        send(16'h4200, 16'h4000, 1'b1);
        sync(); bus.res_ready = 1'b1;
        sync(); bus.res_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_count", fifo_count, 2);
        chk("pushpop_head", bus.res_data, 16'h4000);
        sync(); bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pushpop_order", bus.res_data, 16'h4600);
        repeat (4) sync();

        // reset in the middle of a 3-pair vector
        send(16'h3C00, 16'h3C00, 1'b0);
        send(16'h3C00, 16'h3C00, 1'b0);
        pulse_reset();
        @(negedge clk);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_op_ready", bus.op_ready, 1);
        chk("midrst_fifo_count", fifo_count, 0);
        sync();
        send(16'h3C00, 16'h3C00, 1'b0);
        send(16'h4000, 16'h4000, 1'b1);
        wait3();
        chk("postrst_res_data", bus.res_data, 16'h4500);
        chk("postrst_vec_count", vec_count, 1);

        // narrow vector counter wraps
        sync();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            sync();
            send(16'h4000, 16'h3C00, 1'b1);
            wait3();
            chk($sformatf("wrap_vec_count_%0d", i), vec_count, exp_vc[i]);
        end

        repeat (4) sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
